// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial unsigned adder. One full-adder cell built from two
//               half-adder stages plus a carry flip-flop adds two WIDTH-bit
//               operands LSB-first, one bit per clock. Operands arrive and the
//               sum/carry leave through valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             busy
);

    localparam int              c_CW   = $clog2(WIDTH + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ADD  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_s_sh;
    logic             r_c;
    logic [c_CW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;

    // Full adder as two cascaded half adders.
    logic w_ha0_s, w_ha0_c, w_ha1_s, w_ha1_c;
    logic w_s_bit, w_c_out;
    assign w_ha0_s = r_a_sh[0] ^ r_b_sh[0];
    assign w_ha0_c = r_a_sh[0] & r_b_sh[0];
    assign w_ha1_s = w_ha0_s ^ r_c;
    assign w_ha1_c = w_ha0_s & r_c;
    assign w_s_bit = w_ha1_s;
    assign w_c_out = w_ha0_c | w_ha1_c;

    logic w_accept;
    logic w_last;
    assign w_accept = in_valid && (r_state == c_IDLE);
    assign w_last   = (r_state == c_ADD) && (r_cnt == c_LAST);

    // Sum shift register after inserting the current bit at the MSB.
    logic [WIDTH-1:0] w_s_next;
    generate
        if (WIDTH == 1) begin : g_width1
            assign w_s_next = w_s_bit;
        end else begin : g_widthn
            assign w_s_next = {w_s_bit, r_s_sh[WIDTH-1:1]};
        end
    endgenerate

    // The LSB of the sum shifter falls off the end and is never read.
    logic w_unused_lsb;
    assign w_unused_lsb = r_s_sh[0];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (in_valid)  w_next_state = c_ADD;
            c_ADD:   if (w_last)    w_next_state = c_DONE;
            c_DONE:  if (out_ready) w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // State-decoded handshake outputs.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            c_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            c_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // Serial datapath: operand load, bit-per-cycle add, result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_s_sh  <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
        end else if (w_accept) begin
            r_a_sh <= a;
            r_b_sh <= b;
            r_c    <= 1'b0;
            r_cnt  <= '0;
        end else if (r_state == c_ADD) begin
            r_a_sh <= r_a_sh >> 1;
            r_b_sh <= r_b_sh >> 1;
            r_s_sh <= w_s_next;
            r_c    <= w_c_out;
            r_cnt  <= r_cnt + c_CW'(1);
            if (w_last) begin
                r_sum   <= w_s_next;
                r_carry <= w_c_out;
            end
        end
    end

    assign sum   = r_sum;
    assign carry = r_carry;

endmodule
`default_nettype wire
